// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong ball engine.
package pong_pkg;

    localparam int CORDW_DEFAULT = 12;

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, MISS} ball_state_t;

endpackage

// File: rtl/pong_aabb.sv
// Combinational axis-aligned rectangle overlap test between rectangles A and B.
module pong_aabb #(
    parameter int W = 14
) (
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] aw,
    input  logic [W-1:0] ah,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] bw,
    input  logic [W-1:0] bh,
    output logic         hit
);

    // Callers pass zero-extended operands so the sums never wrap.
    assign hit = (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame Pong ball motion: serve/play/miss sequencing, paddle bounces with speed-up,
// wall bounces, score pulses and a registered ball-draw flag.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int CORDW      = CORDW_DEFAULT,
    parameter int H_RES      = 1920,
    parameter int V_RES      = 1080,
    parameter int B_SIZE     = 24,
    parameter int SP_INIT    = 3,
    parameter int SP_MAX     = 12,
    parameter int SP_INC     = 1,
    parameter int PAD_OFFS   = 32,
    parameter int PAD_W      = 16,
    parameter int PAD_H      = 128,
    parameter int SERVE_WAIT = 60
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             serve,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [CORDW-1:0] pad_l_y,
    input  logic [CORDW-1:0] pad_r_y,
    output logic [CORDW-1:0] bx,
    output logic [CORDW-1:0] by,
    output logic             dx,
    output logic             dy,
    output logic             b_draw,
    output logic             miss_l,
    output logic             miss_r,
    output logic             playing
);

    localparam int AW  = CORDW + 2;
    localparam int SCW = $clog2(SERVE_WAIT + 1);

    localparam logic [CORDW-1:0] X_CTR    = CORDW'((H_RES - B_SIZE) / 2);
    localparam logic [CORDW-1:0] Y_CTR    = CORDW'((V_RES - B_SIZE) / 2);
    localparam logic [CORDW-1:0] SP_V     = CORDW'(SP_INIT);
    localparam logic [CORDW-1:0] Y_BOT    = CORDW'(V_RES - (SP_INIT + B_SIZE));
    localparam logic [CORDW-1:0] X_LIMIT  = CORDW'(H_RES - B_SIZE);
    localparam logic [CORDW-1:0] L_FACE   = CORDW'(PAD_OFFS + PAD_W);
    localparam logic [CORDW-1:0] R_FACE   = CORDW'(H_RES - PAD_OFFS - PAD_W);
    localparam logic [CORDW-1:0] R_BOUNCE = CORDW'(H_RES - PAD_OFFS - PAD_W - B_SIZE);

    ball_state_t      state;
    logic [CORDW-1:0] spx;
    logic [SCW-1:0]   serve_cnt;

    logic             hit_l;
    logic             hit_r;
    logic             on_ball;
    logic [CORDW-1:0] by_nx;
    logic             dy_nx;
    logic [CORDW-1:0] spx_up;
    logic             lost_l;
    logic             lost_r;

    // Paddle zones are widened by spx toward the ball so a fast ball cannot tunnel through.
    pong_aabb #(.W(AW)) u_hit_l (
        .ax(AW'(bx)), .ay(AW'(by)), .aw(AW'(B_SIZE)), .ah(AW'(B_SIZE)),
        .bx(AW'(PAD_OFFS)), .by(AW'(pad_l_y)), .bw(AW'(PAD_W) + AW'(spx)), .bh(AW'(PAD_H)),
        .hit(hit_l)
    );

    pong_aabb #(.W(AW)) u_hit_r (
        .ax(AW'(bx)), .ay(AW'(by)), .aw(AW'(B_SIZE)), .ah(AW'(B_SIZE)),
        .bx(AW'(R_FACE) - AW'(spx)), .by(AW'(pad_r_y)), .bw(AW'(PAD_W) + AW'(spx)), .bh(AW'(PAD_H)),
        .hit(hit_r)
    );

    pong_aabb #(.W(AW)) u_draw (
        .ax(AW'(sx)), .ay(AW'(sy)), .aw(AW'(1)), .ah(AW'(1)),
        .bx(AW'(bx)), .by(AW'(by)), .bw(AW'(B_SIZE)), .bh(AW'(B_SIZE)),
        .hit(on_ball)
    );

    always_comb begin
        by_nx = by + SP_V;
        dy_nx = dy;
        if (by >= Y_BOT) begin
            by_nx = by - SP_V;
            dy_nx = 1'b1;
        end else if (by < SP_V) begin
            by_nx = by + SP_V;
            dy_nx = 1'b0;
        end else if (dy) begin
            by_nx = by - SP_V;
        end
    end

    assign spx_up = (spx >= CORDW'(SP_MAX - SP_INC)) ? CORDW'(SP_MAX) : spx + CORDW'(SP_INC);
    assign lost_l = dx && !hit_l && (bx < spx);
    assign lost_r = !dx && !hit_r && (bx >= X_LIMIT - spx);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bx        <= X_CTR;
            by        <= Y_CTR;
            dx        <= 1'b0;
            dy        <= 1'b0;
            spx       <= CORDW'(SP_INIT);
            serve_cnt <= '0;
            miss_l    <= 1'b0;
            miss_r    <= 1'b0;
            playing   <= 1'b0;
        end else begin
            miss_l <= 1'b0;
            miss_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        spx   <= CORDW'(SP_INIT);
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (frame) begin
                        if (serve_cnt == SCW'(SERVE_WAIT - 1)) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                            playing   <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame) begin
                        if (lost_l || lost_r) begin
                            // The loser receives the next serve.
                            state   <= MISS;
                            playing <= 1'b0;
                            miss_l  <= lost_l;
                            miss_r  <= lost_r;
                            bx      <= X_CTR;
                            by      <= Y_CTR;
                            spx     <= CORDW'(SP_INIT);
                            dx      <= lost_l;
                            dy      <= ~dy;
                        end else begin
                            by <= by_nx;
                            dy <= dy_nx;
                            if (dx) begin
                                if (hit_l) begin
                                    dx  <= 1'b0;
                                    bx  <= L_FACE;
                                    spx <= spx_up;
                                end else begin
                                    bx <= bx - spx;
                                end
                            end else begin
                                if (hit_r) begin
                                    dx  <= 1'b1;
                                    bx  <= R_BOUNCE;
                                    spx <= spx_up;
                                end else begin
                                    bx <= bx + spx;
                                end
                            end
                        end
                    end
                end
                MISS: begin
                    state <= SERVE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The ball is visible in every state, including parked at centre in IDLE.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            b_draw <= 1'b0;
        end else begin
            b_draw <= on_ball;
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized scoreboard bench for pong_ball_engine against a frame-level behavioural model.
module tb_pong_ball_engine;

    localparam int H_RES = 1920;
    localparam int V_RES = 1080;
    localparam int B     = 24;
    localparam int SPI   = 3;
    localparam int SPM   = 12;
    localparam int SPINC = 1;
    localparam int PO    = 32;
    localparam int PW    = 16;
    localparam int PH    = 128;
    localparam int SW    = 60;
    localparam int CX    = (H_RES - B) / 2;
    localparam int CY    = (V_RES - B) / 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_MISS  = 3;

    logic        clk_pix = 1'b0;
    logic        rst_n   = 1'b0;
    logic        frame   = 1'b0;
    logic        serve   = 1'b0;
    logic [11:0] sx      = '0;
    logic [11:0] sy      = '0;
    logic [11:0] pad_l_y = '0;
    logic [11:0] pad_r_y = '0;
    logic [11:0] bx;
    logic [11:0] by;
    logic        dx;
    logic        dy;
    logic        b_draw;
    logic        miss_l;
    logic        miss_r;
    logic        playing;

    typedef struct packed {
        logic [11:0] bx;
        logic [11:0] by;
        logic        dx;
        logic        dy;
        logic        b_draw;
        logic        miss_l;
        logic        miss_r;
        logic        playing;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    int m_phase, m_bx, m_by, m_dx, m_dy, m_spx, m_frames, m_missl, m_missr, m_draw;
    int pl_v = 0;
    int pr_v = 0;
    int m_top_speed = 0;
    int m_scores    = 0;

    pong_ball_engine dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .serve(serve),
        .sx(sx), .sy(sy), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .bx(bx), .by(by), .dx(dx), .dy(dy), .b_draw(b_draw),
        .miss_l(miss_l), .miss_r(miss_r), .playing(playing)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic obs_t dutObs();
        return '{bx: bx, by: by, dx: dx, dy: dy, b_draw: b_draw,
                 miss_l: miss_l, miss_r: miss_r, playing: playing};
    endfunction

    function automatic obs_t modelObs();
        return '{bx: 12'(m_bx), by: 12'(m_by), dx: m_dx[0], dy: m_dy[0], b_draw: m_draw[0],
                 miss_l: m_missl[0], miss_r: m_missr[0], playing: (m_phase == PH_PLAY)};
    endfunction

    function automatic bit overlaps(int a0, int alen, int b0, int blen);
        return (a0 < b0 + blen) && (b0 < a0 + alen);
    endfunction

    function automatic void modelReset();
        m_phase = PH_IDLE;
        m_bx = CX; m_by = CY; m_dx = 0; m_dy = 0; m_spx = SPI;
        m_frames = 0; m_missl = 0; m_missr = 0; m_draw = 0;
    endfunction

    // One clock of the game as seen from outside: draw uses the ball before it moves.
    function automatic void modelStep(bit f, bit s, int px, int py, int pl, int pr);
        int nby, ndy;
        m_draw  = (px >= m_bx && px < m_bx + B && py >= m_by && py < m_by + B);
        m_missl = 0;
        m_missr = 0;
        case (m_phase)
            PH_IDLE: if (s) begin m_spx = SPI; m_phase = PH_SERVE; end
            PH_SERVE: if (f) begin
                m_frames++;
                if (m_frames == SW) begin m_frames = 0; m_phase = PH_PLAY; end
            end
            PH_PLAY: if (f) begin
                if (m_by + SPI + B >= V_RES) begin ndy = 1; nby = m_by - SPI; end
                else if (m_by < SPI)         begin ndy = 0; nby = m_by + SPI; end
                else begin ndy = m_dy; nby = (m_dy == 1) ? m_by - SPI : m_by + SPI; end
                if (m_dx == 1) begin
                    if (overlaps(m_bx, B, PO, PW + m_spx) && overlaps(m_by, B, pl, PH)) begin
                        m_dx = 0; m_bx = PO + PW; m_spx = (m_spx + SPINC > SPM) ? SPM : m_spx + SPINC;
                    end else if (m_bx - m_spx < 0) m_missl = 1;
                    else m_bx = m_bx - m_spx;
                end else begin
                    if (overlaps(m_bx, B, H_RES - PO - PW - m_spx, PW + m_spx) && overlaps(m_by, B, pr, PH)) begin
                        m_dx = 1; m_bx = H_RES - PO - PW - B; m_spx = (m_spx + SPINC > SPM) ? SPM : m_spx + SPINC;
                    end else if (m_bx + m_spx + B >= H_RES) m_missr = 1;
                    else m_bx = m_bx + m_spx;
                end
                if (m_missl == 1 || m_missr == 1) begin
                    m_phase = PH_MISS; m_bx = CX; m_by = CY; m_spx = SPI;
                    m_dx = m_missl; m_dy = 1 - m_dy; m_scores++;
                end else begin
                    m_by = nby; m_dy = ndy;
                end
                if (m_spx > m_top_speed) m_top_speed = m_spx;
            end
            PH_MISS: m_phase = PH_SERVE;
            default: m_phase = PH_IDLE;
        endcase
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got bx=%0d by=%0d dx=%0d dy=%0d draw=%0d ml=%0d mr=%0d play=%0d, want bx=%0d by=%0d dx=%0d dy=%0d draw=%0d ml=%0d mr=%0d play=%0d",
                     name, $time, act.bx, act.by, act.dx, act.dy, act.b_draw, act.miss_l, act.miss_r, act.playing,
                     exp.bx, exp.by, exp.dx, exp.dy, exp.b_draw, exp.miss_l, exp.miss_r, exp.playing);
        end
    endtask

    task automatic applyStimulus(input bit f, input bit s, input int px, input int py);
        frame = f; serve = s; sx = 12'(px); sy = 12'(py);
        pad_l_y = 12'(pl_v); pad_r_y = 12'(pr_v);
        modelStep(f, s, px, py, pl_v, pr_v);
        exp_q.push_back(modelObs());
        @(posedge clk_pix);
        #2;
    endtask

    function automatic int nearBall(int c);
        int v = c + int'($urandom_range(0, B + 7)) - 4;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int padFor(int track);
        int v;
        if (int'($urandom_range(0, 99)) < track) begin
            v = m_by - int'($urandom_range(0, 115));
            return (v < 0) ? 0 : v;
        end
        return int'($urandom_range(0, V_RES - PH));
    endfunction

    // A few idle cycles with the pixel scan near the ball, then one frame pulse.
    task automatic oneFrame(input int track);
        int gap = int'($urandom_range(1, 3));
        pl_v = padFor(track);
        pr_v = padFor(track);
        for (int g = 0; g < gap; g++)
            applyStimulus(1'b0, ($urandom_range(0, 19) == 0), nearBall(m_bx), nearBall(m_by));
        applyStimulus(1'b1, ($urandom_range(0, 19) == 0), nearBall(m_bx), nearBall(m_by));
    endtask

    initial begin
        forever begin
            @(posedge clk_pix);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("cycle", dutObs(), mon_exp);
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        obs_t rst_exp;
        rst_exp = '{bx: 12'(CX), by: 12'(CY), dx: 1'b0, dy: 1'b0, b_draw: 1'b0,
                    miss_l: 1'b0, miss_r: 1'b0, playing: 1'b0};

        repeat (3) @(posedge clk_pix);
        #2;
        checkOutput("reset_values", dutObs(), rst_exp);
        rst_n = 1'b1;
        modelReset();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 0);
            applyStimulus(1'b1, 1'b0, 0, 0);
        end
        for (int y = 0; y < 5; y++) begin
            int ys [5] = '{527, 528, 540, 551, 552};
            for (int x = 944; x <= 976; x++) applyStimulus(1'b0, 1'b0, x, ys[y]);
        end

        applyStimulus(1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 1800 && miscompares < 100; i++) oneFrame(90);

        for (int i = 0; i < 400 && m_phase != PH_PLAY; i++) oneFrame(90);
        for (int i = 0; i < 5; i++) oneFrame(90);
        #1;
        frame = 1'b0;
        serve = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mid_play", dutObs(), rst_exp);
        repeat (2) @(posedge clk_pix);
        #2;
        rst_n = 1'b1;
        modelReset();

        for (int i = 0; i < 4; i++) oneFrame(50);
        applyStimulus(1'b0, 1'b1, CX, CY);
        for (int i = 0; i < 1200 && miscompares < 100; i++) oneFrame(60);

        $display("[TB] model reached speed %0d over %0d scored points", m_top_speed, m_scores);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
